// File: rtl/arb_pkg.sv
// Shared definitions for the N-master bus arbiter: FSM encoding, owner encoding, size limit.
package arb_pkg;

   localparam int ARB_MAX_MASTERS = 8;
   localparam int BUS_GRANT_NONE  = 0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } arb_state_e;

   // bus_grant reserves 0 for "no owner", so master i is reported as i+1
   function automatic int encode_owner(input int idx);
      return idx + 1;
   endfunction

endpackage

// File: rtl/arb_rr_picker.sv
// Combinational rotating-priority picker: first set request at or above ptr_i, wrapping.
module arb_rr_picker #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     winner_o,
   output logic [IDX_W-1:0] idx_o
);

   always_comb begin
      int best_k;
      int best_d;
      int d;
      best_k   = 0;
      best_d   = N;
      winner_o = '0;
      // distance from the pointer in wrap-around order; the smallest distance wins
      for (int k = 0; k < N; k++) begin
         d = (k >= int'(ptr_i)) ? (k - int'(ptr_i)) : (k + N - int'(ptr_i));
         if (req_i[k] && (d < best_d)) begin
            best_k = k;
            best_d = d;
         end
      end
      idx_o = IDX_W'(best_k);
      for (int k = 0; k < N; k++) begin
         winner_o[k] = (|req_i) && (best_k == k);
      end
   end

endmodule

// File: rtl/bus_arbiter_n.sv
// N-master bus arbiter with grant hold, one-cycle release turnaround and slave-select forwarding.
// Optional forced release after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
module bus_arbiter_n
   import arb_pkg::*;
#(
   parameter int NUM_MASTERS = 4,
   parameter int SLAVE_SEL_W = 2,
   parameter int RR_MODE     = 0,
   parameter int MAX_HOLD    = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_MASTERS-1:0]               req,
   input  logic [NUM_MASTERS*SLAVE_SEL_W-1:0]   slave_sel_in,
   output logic [NUM_MASTERS-1:0]               grant,
   output logic                                 arbiter_busy,
   output logic [$clog2(NUM_MASTERS+1)-1:0]     bus_grant,
   output logic [SLAVE_SEL_W-1:0]               slave_sel,
   output logic                                 timeout_pulse
);

   localparam int IDX_W = $clog2(NUM_MASTERS);
   localparam int BG_W  = $clog2(NUM_MASTERS+1);

   if (NUM_MASTERS < 2 || NUM_MASTERS > ARB_MAX_MASTERS || MAX_HOLD < 2) begin : g_bad_cfg
      $error("bus_arbiter_n: unsupported NUM_MASTERS/MAX_HOLD");
   end

   arb_state_e               state_q, state_d;
   logic [NUM_MASTERS-1:0]   grant_q, grant_d;
   logic                     busy_q, busy_d;
   logic [BG_W-1:0]          bus_grant_q, bus_grant_d;
   logic [SLAVE_SEL_W-1:0]   slave_sel_q, slave_sel_d;
   logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;

   logic [NUM_MASTERS-1:0]   win_oh;
   logic [IDX_W-1:0]         win_idx;
   logic [IDX_W-1:0]         pick_ptr;
   logic [SLAVE_SEL_W-1:0]   win_sel;
   logic                     owner_req;

`ifdef ARB_TIMEOUT_EN
   localparam int HOLD_W = $clog2(MAX_HOLD);
   logic [HOLD_W-1:0]        hold_q, hold_d;
   logic                     timeout_q, timeout_d;
`endif

   assign pick_ptr  = (RR_MODE != 0) ? rr_ptr_q : '0;
   // grant_q is one-hot, so this is the current owner's request bit
   assign owner_req = |(req & grant_q);

   arb_rr_picker #(
      .N     (NUM_MASTERS),
      .IDX_W (IDX_W)
   ) u_picker (
      .req_i    (req),
      .ptr_i    (pick_ptr),
      .winner_o (win_oh),
      .idx_o    (win_idx)
   );

   always_comb begin
      win_sel = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (win_oh[k]) win_sel = slave_sel_in[k*SLAVE_SEL_W +: SLAVE_SEL_W];
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      busy_d      = busy_q;
      bus_grant_d = bus_grant_q;
      slave_sel_d = slave_sel_q;
      rr_ptr_d    = rr_ptr_q;
`ifdef ARB_TIMEOUT_EN
      hold_d      = hold_q;
      timeout_d   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d     = GRANT;
               grant_d     = win_oh;
               busy_d      = 1'b1;
               bus_grant_d = BG_W'(encode_owner(int'(win_idx)));
               slave_sel_d = win_sel;
               rr_ptr_d    = (win_idx == IDX_W'(NUM_MASTERS-1)) ? '0 : win_idx + 1'b1;
`ifdef ARB_TIMEOUT_EN
               hold_d      = '0;
`endif
            end
         end
         GRANT: begin
            if (!owner_req) begin
               state_d     = RELEASE;
               grant_d     = '0;
               busy_d      = 1'b0;
               bus_grant_d = BG_W'(BUS_GRANT_NONE);
               slave_sel_d = '0;
            end
`ifdef ARB_TIMEOUT_EN
            else if (hold_q == HOLD_W'(MAX_HOLD-1)) begin
               state_d     = RELEASE;
               grant_d     = '0;
               busy_d      = 1'b0;
               bus_grant_d = BG_W'(BUS_GRANT_NONE);
               slave_sel_d = '0;
               timeout_d   = 1'b1;
            end else begin
               hold_d      = hold_q + 1'b1;
            end
`endif
         end
         RELEASE: begin
            state_d = IDLE;
         end
         default: begin
            state_d     = IDLE;
            grant_d     = '0;
            busy_d      = 1'b0;
            bus_grant_d = BG_W'(BUS_GRANT_NONE);
            slave_sel_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         busy_q      <= 1'b0;
         bus_grant_q <= '0;
         slave_sel_q <= '0;
         rr_ptr_q    <= '0;
`ifdef ARB_TIMEOUT_EN
         hold_q      <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         busy_q      <= busy_d;
         bus_grant_q <= bus_grant_d;
         slave_sel_q <= slave_sel_d;
         rr_ptr_q    <= rr_ptr_d;
`ifdef ARB_TIMEOUT_EN
         hold_q      <= hold_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

   assign grant        = grant_q;
   assign arbiter_busy = busy_q;
   assign bus_grant    = bus_grant_q;
   assign slave_sel    = slave_sel_q;
`ifdef ARB_TIMEOUT_EN
   assign timeout_pulse = timeout_q;
`else
   assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Bench for bus_arbiter_n: fixed-priority (dut0) and round-robin (dut1) instances, MAX_HOLD=4.
`timescale 1ns/1ps
module tb_bus_arbiter_n;

   typedef struct packed {
      logic [3:0] g;
      logic       busy;
      logic [2:0] bg;
      logic [1:0] ss;
      logic       to;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = '0;
   logic [7:0] sel = '0;

   logic [3:0] grant0, grant1;
   logic       busy0, busy1, to0, to1;
   logic [2:0] bg0, bg1;
   logic [1:0] ss0, ss1;
   obs_t       obs0, obs1;

   int   passed = 0;
   int   total  = 0;
   obs_t sb[$];

   always #5 clk = ~clk;

   bus_arbiter_n #(.NUM_MASTERS(4), .SLAVE_SEL_W(2), .RR_MODE(0), .MAX_HOLD(4)) dut0 (
      .clk(clk), .rst(rst), .req(req), .slave_sel_in(sel),
      .grant(grant0), .arbiter_busy(busy0), .bus_grant(bg0),
      .slave_sel(ss0), .timeout_pulse(to0));

   bus_arbiter_n #(.NUM_MASTERS(4), .SLAVE_SEL_W(2), .RR_MODE(1), .MAX_HOLD(4)) dut1 (
      .clk(clk), .rst(rst), .req(req), .slave_sel_in(sel),
      .grant(grant1), .arbiter_busy(busy1), .bus_grant(bg1),
      .slave_sel(ss1), .timeout_pulse(to1));

   assign obs0 = {grant0, busy0, bg0, ss0, to0};
   assign obs1 = {grant1, busy1, bg1, ss1, to1};

   // Expected outputs for owner 'own' (-1 = none); with sel=8'hE4 master i selects slave i
   function automatic obs_t mk(input int own, input logic to);
      obs_t e;
      e    = '0;
      e.to = to;
      if (own >= 0) begin
         e.g    = 4'(1 << own);
         e.busy = 1'b1;
         e.bg   = 3'(own + 1);
         e.ss   = 2'(own);
      end
      return e;
   endfunction

   task automatic cyc(input logic [3:0] r, input logic [7:0] s);
      req = r;
      sel = s;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(4'b0000, 8'h00);
      cyc(4'b0000, 8'h00);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      obs_t e;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         sb.push_back(mk(-1, 1'b0));
         cyc(4'b1111, 8'hE4);
         e = sb.pop_front();
         total++;
         if (obs0 !== e) $display("FAIL reset_fp c%0d: got %b want %b", i, obs0, e);
         else passed++;
         total++;
         if (obs1 !== e) $display("FAIL reset_rr c%0d: got %b want %b", i, obs1, e);
         else passed++;
      end
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         sb.push_back(mk(0, 1'b0));
         cyc(4'b1111, 8'hE4);
         e = sb.pop_front();
         total++;
         if (obs0 !== e) $display("FAIL reset_release_fp c%0d: got %b want %b", i, obs0, e);
         else passed++;
         total++;
         if (obs1 !== e) $display("FAIL reset_release_rr c%0d: got %b want %b", i, obs1, e);
         else passed++;
      end
   endtask

   task automatic test_hold();
      logic [3:0] rq [7];
      logic [7:0] sl [7];
      int         own [7];
      obs_t       e;
      rq  = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
      sl  = '{8'h30, 8'h30, 8'h00, 8'h00, 8'h30, 8'h30, 8'h30};
      own = '{2, 2, 2, 2, 2, -1, -1};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         e = mk(own[i], 1'b0);
         if (own[i] == 2) e.ss = 2'd3;
         sb.push_back(e);
         cyc(rq[i], sl[i]);
         e = sb.pop_front();
         total++;
         if (obs0 !== e) $display("FAIL hold c%0d: got %b want %b", i, obs0, e);
         else passed++;
      end
   endtask

   task automatic test_priority();
      logic [3:0] rq [12];
      int         own [12];
      obs_t       e;
      rq  = '{4'b1010, 4'b1010, 4'b1000, 4'b1000, 4'b1000, 4'b1001,
              4'b1001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
      own = '{1, 1, -1, -1, 3, 3, 3, -1, -1, 0, -1, -1};
      do_reset();
      for (int i = 0; i < 12; i++) begin
         sb.push_back(mk(own[i], 1'b0));
         cyc(rq[i], 8'hE4);
         e = sb.pop_front();
         total++;
         if (obs0 !== e) $display("FAIL priority c%0d: got %b want %b", i, obs0, e);
         else passed++;
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] rq [15];
      int         own [15];
      obs_t       e;
      rq  = '{4'b1111, 4'b1110, 4'b1111, 4'b1111, 4'b1101, 4'b1111, 4'b1111, 4'b1011,
              4'b1111, 4'b1111, 4'b0111, 4'b1111, 4'b1111, 4'b0000, 4'b0000};
      own = '{0, -1, -1, 1, -1, -1, 2, -1, -1, 3, -1, -1, 0, -1, -1};
      do_reset();
      for (int i = 0; i < 15; i++) begin
         sb.push_back(mk(own[i], 1'b0));
         cyc(rq[i], 8'hE4);
         e = sb.pop_front();
         total++;
         if (obs1 !== e) $display("FAIL round_robin c%0d: got %b want %b", i, obs1, e);
         else passed++;
      end
   endtask

   task automatic test_timeout();
      logic [3:0] rq [9];
      int         own [9];
      logic       tp [9];
      obs_t       e;
      rq  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
`ifdef ARB_TIMEOUT_EN
      own = '{0, 0, 0, 0, -1, -1, 0, -1, -1};
      tp  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`else
      own = '{0, 0, 0, 0, 0, 0, 0, -1, -1};
      tp  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
      do_reset();
      for (int i = 0; i < 9; i++) begin
         sb.push_back(mk(own[i], tp[i]));
         cyc(rq[i], 8'hE4);
         e = sb.pop_front();
         total++;
         if (obs0 !== e) $display("FAIL timeout_fp c%0d: got %b want %b", i, obs0, e);
         else passed++;
         total++;
         if (obs1 !== e) $display("FAIL timeout_rr c%0d: got %b want %b", i, obs1, e);
         else passed++;
      end
   endtask

   task automatic test_reset_mid_grant();
      logic [3:0] rq [9];
      logic       rs [9];
      int         own [9];
      obs_t       e;
      rq  = '{4'b1000, 4'b1000, 4'b1111, 4'b1111, 4'b0000, 4'b0010, 4'b0010, 4'b1111, 4'b1111};
      rs  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      own = '{3, 3, -1, 0, -1, -1, 1, -1, 0};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         rst = rs[i];
         sb.push_back(mk(own[i], 1'b0));
         cyc(rq[i], 8'hE4);
         e = sb.pop_front();
         total++;
         if (obs1 !== e) $display("FAIL reset_mid_grant c%0d: got %b want %b", i, obs1, e);
         else passed++;
      end
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, total);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_hold();
      test_priority();
      test_round_robin();
      test_timeout();
      test_reset_mid_grant();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/bus_arbiter_n.md
Name: bus_arbiter_n

Overview:
Parametrised N-master system-bus arbiter. It is the successor to the fixed two-master arbiter. It adds a selectable fixed-priority or round-robin policy, grant hold (bus lock) for as long as the owner keeps requesting, a one-cycle release turnaround, and per-master slave-select forwarding. It sits between the master interfaces and the bus/slave decoder.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..8)
SLAVE_SEL_W, 2, width of each master's slave-select field
RR_MODE, 0, 0 = fixed priority (master 0 highest); 1 = round-robin
MAX_HOLD, 16, cycles before forced release (only used with ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
req  in  NUM_MASTERS  per-master bus request, bit i = master i
slave_sel_in  in  NUM_MASTERS*SLAVE_SEL_W  packed slave selects; master i occupies [i*SLAVE_SEL_W +: SLAVE_SEL_W]
grant  out  NUM_MASTERS  one-hot grant, registered
arbiter_busy  out  1  high while any grant is active
bus_grant  out  $clog2(NUM_MASTERS+1)  encoded owner: 0 = none, i+1 = master i
slave_sel  out  SLAVE_SEL_W  slave select latched from the owner at grant time
timeout_pulse  out  1  one-cycle pulse on forced release (tied 0 without ARB_TIMEOUT_EN)

Behaviour:
- Single clock domain clk. rst is synchronous and active-high and takes priority over all other logic.
- Reset values: grant=0, arbiter_busy=0, bus_grant=0, slave_sel=0, timeout_pulse=0, state=IDLE, rr_ptr=0, hold counter=0.
- All outputs are registered. No combinational path from req to any output.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If req != 0, select a winner and go to GRANT.
  - On the same edge: grant[w]=1, busy=1, bus_grant=w+1, slave_sel=slave_sel_in[w].
  - Latency: req sampled high at edge k means grant is visible after edge k (one cycle).
  - If req == 0, stay in IDLE with all outputs 0.
- Winner selection:
  - RR_MODE=0: lowest index among set req bits.
  - RR_MODE=1: first set bit at or above rr_ptr, wrapping modulo NUM_MASTERS.
  - On every grant, rr_ptr <= (w+1) mod NUM_MASTERS.
- GRANT:
  - Hold grant, bus_grant and slave_sel unchanged while req[owner]=1. Other requests are ignored; there is no preemption, even by a higher-priority master.
  - slave_sel_in changes during GRANT are ignored.
  - When req[owner]=0, go to RELEASE and clear grant, busy, bus_grant and slave_sel.
- RELEASE:
  - Exactly one cycle with all outputs 0 (bus turnaround). Then go to IDLE.
  - Requests are not arbitrated in RELEASE. A pending request is granted 2 cycles after the owner drops.
- Simultaneous requests in IDLE: exactly one grant. grant is always one-hot or zero.
- A request that drops during RELEASE is not granted.
- rst asserted mid-GRANT: outputs are 0 on the next edge and rr_ptr returns to 0.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the count reaches MAX_HOLD-1 with req[owner] still high, go to RELEASE and pulse timeout_pulse for one cycle.
  - In RR_MODE=1 the timed-out master loses priority through the normal rr_ptr update.
  - In RR_MODE=0 the timed-out master may win again immediately if it is the highest-priority requester.
- Undefined: there is no counter, a grant holds indefinitely, and timeout_pulse is constant 0.

Decomposition:
- Package arb_pkg holds:
  - the FSM state enum (IDLE=0, GRANT=1, RELEASE=2; 2-bit)
  - the encoding rule for bus_grant (0 = none)
  - the NUM_MASTERS upper bound of 8
- Sub-module arb_rr_picker:
  - Combinational. Inputs: req and ptr. Outputs: one-hot winner and index.
  - Fixed priority is ptr tied to 0.
  - Instantiated once by bus_arbiter_n and unit-testable alone.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111 -> all outputs 0. Release rst with req=4'b1111, RR_MODE=0 -> next edge grant=0001, bus_grant=1, busy=1.
- Hold and turnaround: master 2 alone, slave_sel_in[2]=2'b11, held 5 cycles -> grant=0100 for 5 cycles, slave_sel=3. On drop: 1 cycle all-zero, then IDLE.
- Priority: RR_MODE=0, req=1010 -> master 1 granted. Master 3 is granted only after master 1 drops and the RELEASE cycle passes. Master 0 raising req during master 3's GRANT does not preempt.
- Round-robin: RR_MODE=1, req=1111 held, each owner releasing after 1 cycle (owner's req pulses low for one cycle) -> grant order 0,1,2,3,0 with a RELEASE cycle between each.
- Timeout: ARB_TIMEOUT_EN, MAX_HOLD=4, master 0 holds req -> grant for 4 cycles, then timeout_pulse=1 with grant=0, then regrant to master 0 (RR_MODE=0).
- Reset mid-grant: rst during master 3's GRANT in RR_MODE=1 -> outputs 0 on the next edge. With req=1111 after reset, master 0 wins (rr_ptr=0).
